// File: rtl/as_muldivrv.sv
// Iterative RV64 M-extension multiply/divide unit: radix-2^STEP shift-add multiplier and restoring divider.
// Optional macro AS_MULDIV_EARLYOUT_EN: zero-operand multiplies and divide-by-zero complete one cycle after accept.
module as_muldivrv #(
   parameter int DATA_W = 64,
   parameter int STEP   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [3:0]        op_i,
   input  logic [DATA_W-1:0] data01_i,
   input  logic [DATA_W-1:0] data02_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] result_o,
   output logic              busy_o,
   output logic              illegal_o
);
   localparam int CNT_W = $clog2(DATA_W / STEP);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W / STEP - 1);
   localparam logic [CNT_W-1:0] CNT_W32  = CNT_W'(32 / STEP - 1);
   localparam int WSH = DATA_W - 32;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
   localparam logic [3:0] OP_MUL = 4'd0, OP_MULH = 4'd1, OP_MULHSU = 4'd2, OP_MULHU = 4'd3,
                          OP_DIV = 4'd4, OP_REM = 4'd6, OP_REMU = 4'd7, OP_MULW = 4'd8,
                          OP_DIVW = 4'd9, OP_REMW = 4'd11, OP_REMUW = 4'd12;

   function automatic logic is_w(input logic [3:0] op);
      return op >= OP_MULW && op <= OP_REMUW;
   endfunction
   function automatic logic is_mul(input logic [3:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
   endfunction
   function automatic logic is_high(input logic [3:0] op);
      return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction
   function automatic logic is_rem(input logic [3:0] op);
      return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
   endfunction
   function automatic logic a_signed(input logic [3:0] op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
   endfunction
   function automatic logic b_signed(input logic [3:0] op);
      return op inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
   endfunction
   function automatic logic is_legal(input logic [3:0] op);
      return op <= OP_REMUW && (DATA_W != 32 || op < OP_MULW);
   endfunction

   state_e              state_q;
   logic [3:0]          op_q;
   logic [DATA_W-1:0]   hi_q, lo_q, opb_q, result_q;
   logic [DATA_W-1:0]   hi_d, lo_d;
   logic [CNT_W-1:0]    cnt_q;
   logic                neg_q, rneg_q, valid_q, illegal_q;

   logic [DATA_W-1:0]   ext_a, ext_b, mag_a, mag_b;
   logic                sgn_a, sgn_b;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      ext_a = data01_i;
      ext_b = data02_i;
      if (is_w(op_i)) begin
         ext_a = a_signed(op_i) ? DATA_W'($signed(data01_i[31:0])) : DATA_W'(data01_i[31:0]);
         ext_b = b_signed(op_i) ? DATA_W'($signed(data02_i[31:0])) : DATA_W'(data02_i[31:0]);
      end
      sgn_a = a_signed(op_i) & ext_a[DATA_W-1];
      sgn_b = b_signed(op_i) & ext_b[DATA_W-1];
      mag_a = sgn_a ? -ext_a : ext_a;
      mag_b = sgn_b ? -ext_b : ext_b;
   end

`ifdef AS_MULDIV_EARLYOUT_EN
   logic                early_hit;
   logic [DATA_W-1:0]   early_val;
   always_comb begin
      early_hit = is_mul(op_i) ? (ext_a == '0 || ext_b == '0) : (ext_b == '0);
      early_val = '1;
      if (is_mul(op_i))      early_val = '0;
      else if (is_rem(op_i)) early_val = ext_a;
      if (is_w(op_i))        early_val = DATA_W'($signed(early_val[31:0]));
   end
`endif

   // One iteration cycle: STEP multiplier bits retired, or STEP quotient bits produced.
   logic [DATA_W:0] part;
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      part = '0;
      for (int i = 0; i < STEP; i++) begin
         if (is_mul(op_q)) begin
            part = {1'b0, hi_d} + (lo_d[0] ? {1'b0, opb_q} : '0);
            hi_d = part[DATA_W:1];
            lo_d = {part[0], lo_d[DATA_W-1:1]};
         end else begin
            part = {hi_d, lo_d[DATA_W-1]};
            lo_d = {lo_d[DATA_W-2:0], 1'b0};
            if (part >= {1'b0, opb_q}) begin
               part    = part - {1'b0, opb_q};
               lo_d[0] = 1'b1;
            end
            hi_d = part[DATA_W-1:0];
         end
      end
   end

   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   quo, rem, fix_res;
   always_comb begin
      prod = {hi_q, lo_q};
      if (is_w(op_q)) prod = prod >> WSH;
      if (neg_q)      prod = -prod;
      quo = neg_q  ? -lo_q : lo_q;
      rem = rneg_q ? -hi_q : hi_q;
      if (is_mul(op_q)) fix_res = is_high(op_q) ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
      else              fix_res = is_rem(op_q) ? rem : quo;
      if (is_w(op_q))   fix_res = DATA_W'($signed(fix_res[31:0]));
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         op_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         opb_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         result_q  <= '0;
      end else if (flush_i) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (valid_i) begin
               op_q <= op_i;
               if (!is_legal(op_i)) begin
                  state_q   <= DONE;
                  valid_q   <= 1'b1;
                  illegal_q <= 1'b1;
                  result_q  <= '0;
`ifdef AS_MULDIV_EARLYOUT_EN
               end else if (early_hit) begin
                  state_q   <= DONE;
                  valid_q   <= 1'b1;
                  illegal_q <= 1'b0;
                  result_q  <= early_val;
`endif
               end else begin
                  state_q   <= CALC;
                  illegal_q <= 1'b0;
                  cnt_q     <= is_w(op_i) ? CNT_W32 : CNT_FULL;
                  hi_q      <= '0;
                  rneg_q    <= sgn_a;
                  if (is_mul(op_i)) begin
                     lo_q  <= mag_b;
                     opb_q <= mag_a;
                     neg_q <= sgn_a ^ sgn_b;
                  end else begin
                     // W dividends are pre-aligned so their 32 bits shift out first.
                     lo_q  <= is_w(op_i) ? (mag_a << WSH) : mag_a;
                     opb_q <= mag_b;
                     neg_q <= (sgn_a ^ sgn_b) & (ext_b != '0);
                  end
               end
            end
            CALC: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= FIX;
            end
            FIX: begin
               result_q <= fix_res;
               valid_q  <= 1'b1;
               state_q  <= DONE;
            end
            DONE: if (ready_i) begin
               valid_q   <= 1'b0;
               illegal_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o   = (state_q == IDLE);
   assign busy_o    = (state_q != IDLE);
   assign valid_o   = valid_q;
   assign illegal_o = illegal_q;
   assign result_o  = result_q;
endmodule

// File: tb/tb_as_muldivrv.sv
// Bench for as_muldivrv: STEP=1 and STEP=2 instances checked against an arithmetic reference model.
module tb_as_muldivrv;
   localparam int W = 64;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, flush;
   logic         v1_i, rdy1_i, v2_i, rdy2_i;
   logic [3:0]   op1, op2;
   logic [W-1:0] a1, b1, a2, b2;
   logic         ready1, v1_o, busy1, ill1, ready2, v2_o, busy2, ill2;
   logic [W-1:0] res1, res2;

   as_muldivrv #(.DATA_W(64), .STEP(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(v1_i), .ready_o(ready1),
      .op_i(op1), .data01_i(a1), .data02_i(b1), .valid_o(v1_o), .ready_i(rdy1_i),
      .result_o(res1), .busy_o(busy1), .illegal_o(ill1));

   as_muldivrv #(.DATA_W(64), .STEP(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(v2_i), .ready_o(ready2),
      .op_i(op2), .data01_i(a2), .data02_i(b2), .valid_o(v2_o), .ready_i(rdy2_i),
      .result_o(res2), .busy_o(busy2), .illegal_o(ill2));

   int          total = 0, bad = 0;
   logic        sel = 1'b0, checking = 1'b0, exp_ill = 1'b0;
   logic [63:0] exp_res = '0;

   wire         s_valid = sel ? v2_o   : v1_o;
   wire         s_ready = sel ? ready2 : ready1;
   wire         s_busy  = sel ? busy2  : busy1;
   wire         s_ill   = sel ? ill2   : ill1;
   wire [63:0]  s_res   = sel ? res2   : res1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain SV arithmetic on the RISC-V definitions.
   function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [127:0]       p;
      logic signed [63:0] sa, sb;
      logic signed [31:0] wa, wb;
      logic [31:0]        ua, ub, r32;
      sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      r32 = '0; model = '0;
      case (op)
         4'd0: model = a * b;
         4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; model = p[127:64]; end
         4'd2: begin p = {{64{a[63]}}, a} * {64'b0, b};       model = p[127:64]; end
         4'd3: begin p = {64'b0, a} * {64'b0, b};             model = p[127:64]; end
         4'd4: if (b == 0) model = ONES; else if (a == MIN && b == ONES) model = a; else model = sa / sb;
         4'd5: model = (b == 0) ? ONES : a / b;
         4'd6: if (b == 0) model = a; else if (a == MIN && b == ONES) model = 0; else model = sa % sb;
         4'd7: model = (b == 0) ? a : a % b;
         4'd8: r32 = ua * ub;
         4'd9: if (wb == 0) r32 = '1; else if (ua == 32'h8000_0000 && wb == -1) r32 = ua; else r32 = wa / wb;
         4'd10: r32 = (ub == 0) ? '1 : ua / ub;
         4'd11: if (wb == 0) r32 = ua; else if (ua == 32'h8000_0000 && wb == -1) r32 = 0; else r32 = wa % wb;
         4'd12: r32 = (ub == 0) ? ua : ua % ub;
         default: model = '0;
      endcase
      if (op >= 4'd8 && op <= 4'd12) model = {{32{r32[31]}}, r32};
   endfunction

   // Cycles counted with the accept edge as cycle 1.
   function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int step);
      logic w;
      if (op > 4'd12) return 1;
      w = (op >= 4'd8);
`ifdef AS_MULDIV_EARLYOUT_EN
      begin
         logic        mul;
         logic [63:0] ea, eb;
         mul = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
         ea  = w ? {32'b0, a[31:0]} : a;
         eb  = w ? {32'b0, b[31:0]} : b;
         if (mul && (ea == 0 || eb == 0)) return 1;
         if (!mul && eb == 0) return 1;
      end
`endif
      return (w ? 32 : 64) / step + 2;
   endfunction

   // While a result is presented it must match the expectation every cycle.
   always @(negedge clk) begin
      if (checking && s_valid) begin
         check("done_result",  s_res,   exp_res);
         check("done_illegal", 64'(s_ill),   64'(exp_ill));
         check("done_ready",   64'(s_ready), 64'd0);
         check("done_busy",    64'(s_busy),  64'd1);
      end
   end

   task automatic drive(input logic s, input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      if (s) begin v2_i = v; op2 = op; a2 = a; b2 = b; end
      else   begin v1_i = v; op1 = op; a1 = a; b1 = b; end
   endtask

   // Called #1 after a rising edge with the selected unit idle.
   task automatic run_op(input logic s, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic ei, input int lat, input int hold, input string name);
      int cycles;
      sel = s; exp_res = er; exp_ill = ei;
      check({name, " ready_idle"}, 64'(s_ready), 64'd1);
      drive(s, 1'b1, op, a, b);
      @(posedge clk);
      cycles = 1;
      checking = 1'b1;
      #1;
      drive(s, 1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      while (!s_valid && cycles < 300) begin
         @(posedge clk);
         cycles++;
         #1;
      end
      check({name, " latency"}, 64'(cycles), 64'(lat));
      repeat (hold) begin @(posedge clk); #1; end
      if (s) rdy2_i = 1'b1; else rdy1_i = 1'b1;
      @(posedge clk);
      #1;
      rdy1_i = 1'b0; rdy2_i = 1'b0;
      checking = 1'b0;
      check({name, " released"}, 64'({s_valid, s_ready}), 64'b01);
   endtask

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return ONES;
         2: return MIN;
         3: return 64'($signed(7'($urandom_range(0, 127))));
         4: return {32'($urandom), 32'h8000_0000};
         5: return {32'($urandom), 32'hFFFF_FFFF};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0]  op;
      logic [63:0] a, b;
      int          seen;
      rst = 1'b1; flush = 1'b0;
      v1_i = 0; rdy1_i = 0; op1 = 0; a1 = 0; b1 = 0;
      v2_i = 0; rdy2_i = 0; op2 = 0; a2 = 0; b2 = 0;
      #12;
      check("reset ready",   64'(ready1), 64'd1);
      check("reset valid",   64'(v1_o),   64'd0);
      check("reset busy",    64'(busy1),  64'd0);
      check("reset illegal", 64'(ill1),   64'd0);
      check("reset result",  res1,        64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(0, 4'd1,  ONES, 64'd2, ONES, 0, 66, 0, "mulh_m1_2");
      run_op(0, 4'd4,  MIN, ONES, MIN, 0, 66, 0, "div_ovf");
      run_op(0, 4'd6,  MIN, ONES, 64'd0, 0, 66, 0, "rem_ovf");
      run_op(0, 4'd5,  64'd7, 64'd0, ONES, 0, exp_lat(4'd5, 64'd7, 64'd0, 1), 0, "divu_by0");
      run_op(0, 4'd7,  64'd7, 64'd0, 64'd7, 0, exp_lat(4'd7, 64'd7, 64'd0, 1), 0, "remu_by0");
      run_op(0, 4'd10, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 0, 34, 0, "divuw");
      run_op(0, 4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 0, 34, 0, "remw_m7_2");
      run_op(0, 4'd0,  64'd3, 64'd5, 64'd15, 0, 66, 5, "mul_hold");
      run_op(1, 4'd1,  ONES, 64'd2, ONES, 0, 34, 0, "s2_mulh_m1_2");

      // Flush mid-CALC, with a competing request in the flush cycle.
      sel = 0;
      drive(0, 1'b1, 4'd4, 64'd1000, 64'd3);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'd0, 0, 0);
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      drive(0, 1'b1, 4'd0, 64'd1, 64'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      drive(0, 1'b0, 4'd0, 0, 0);
      check("flush idle", 64'({busy1, ready1, v1_o}), 64'b010);
      seen = 0;
      repeat (80) begin @(posedge clk); #1; if (v1_o) seen = 1; end
      check("flush no_valid", 64'(seen), 64'd0);

      // Asynchronous reset in the middle of a multiply, then an undefined op.
      drive(0, 1'b1, 4'd0, 64'd12345, 64'd678);
      @(posedge clk); #1;
      drive(0, 1'b0, 4'd0, 0, 0);
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst ready",   64'(ready1), 64'd1);
      check("midrst valid",   64'(v1_o),   64'd0);
      check("midrst busy",    64'(busy1),  64'd0);
      check("midrst illegal", 64'(ill1),   64'd0);
      check("midrst result",  res1,        64'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      run_op(0, 4'd13, 64'd9, 64'd9, 64'd0, 1, 1, 2, "illegal13");

      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 15));
         a = rnd64(); b = rnd64();
         run_op(0, op, a, b, model(op, a, b), op > 4'd12, exp_lat(op, a, b, 1),
                $urandom_range(0, 2), $sformatf("s1_rand op%0d", op));
      end
      for (int i = 0; i < 30; i++) begin
         op = (i < 15) ? 4'd0 : 4'($urandom_range(0, 15));
         a = rnd64(); b = rnd64();
         run_op(1, op, a, b, model(op, a, b), op > 4'd12, exp_lat(op, a, b, 2),
                $urandom_range(0, 2), $sformatf("s2_rand op%0d", op));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/as_muldivrv.md
Name: as_muldivrv

Overview:
- Iterative integer multiply/divide unit for the RV64I core: the RISC-V M extension plus the RV64 W-variants.
- Sits beside the single-cycle ALU in the execute stage and is width-generic (32/64).
- Accepts one operation at a time through a valid/ready handshake.
- Runs a radix-2^STEP shift-add multiplier or restoring divider, then holds the result until the consumer takes it.

Parameters:
- DATA_W, 64, operand/result width; legal values 32 or 64.
- STEP, 1, bits retired per iteration cycle; legal values 1 or 2; DATA_W and 32 must be divisible by STEP.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  abort any operation in flight (pipeline flush).
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept a request.
- op_i  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW.
- data01_i  in  DATA_W  rs1 operand.
- data02_i  in  DATA_W  rs2 operand.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts the result.
- result_o  out  DATA_W  result.
- busy_o  out  1  state is not IDLE.
- illegal_o  out  1  qualifies valid_o; the accepted op was undefined.

Behaviour:
- Interface: one clock (clk_i); reset rst_i asynchronous, active-high.
- Reset values: state IDLE; ready_o=1; valid_o=0; busy_o=0; illegal_o=0; result_o=0; all internal registers 0.
- States are IDLE, CALC, FIX, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o, capture op and operands and go to CALC.
  - Captured operands are converted to magnitudes per the signedness of the op.
  - W-ops use bits [31:0]; signed W-ops sign-extend those bits, unsigned W-ops zero-extend them.
- CALC:
  - Runs N=OPW/STEP cycles, where OPW=32 for W-ops and DATA_W otherwise.
  - The iteration counter counts down from N-1; leave CALC when it reaches 0.
  - Multiply: 2*OPW-bit unsigned product of the magnitudes.
  - Divide: restoring algorithm, STEP quotient bits per cycle.
- FIX (1 cycle):
  - Apply sign correction:
    - Product is negated if the operand signs differ (MULHSU: sign of data01 only).
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - Select the output half: MUL and MULW take the low part; MULH, MULHSU and MULHU take the high DATA_W bits.
  - W-ops: result_o = sign-extended bit 31 of the 32-bit result, for all W-ops including the unsigned ones.
  - Register result_o and go to DONE.
- DONE:
  - valid_o=1; result_o is stable.
  - Go to IDLE on ready_i; otherwise hold indefinitely.
  - ready_o=0 in DONE, so no back-to-back overlap.
- Latency: valid_o rises N+2 cycles after the accept edge. Example: DATA_W=64, STEP=1, MUL gives 66; DIVW gives 34.
- Divide by zero:
  - Quotient = all ones.
  - Remainder = dividend (after W truncation/extension).
  - Runs the full latency.
- Signed overflow (dividend = most negative, divisor = -1):
  - Quotient = dividend.
  - Remainder = 0.
- Illegal op (op_i>12, or op_i>=8 with DATA_W=32):
  - IDLE goes directly to DONE.
  - result_o=0, illegal_o=1.
- flush_i:
  - Highest priority in every state: next state IDLE, valid_o=0, result discarded.
  - valid_i in the same cycle as flush_i is ignored.
- rst_i mid-operation: immediate return to all reset values; no partial result appears.
- Operands are sampled only at accept; input changes during CALC have no effect.

Optional Feature:
- Macro AS_MULDIV_EARLYOUT_EN.
- Defined:
  - Divide-by-zero, and multiply with either operand zero, skip CALC and FIX.
  - IDLE goes directly to DONE with the spec result, so valid_o rises 1 cycle after accept.
- Undefined: every legal op takes the full N+2 latency.
- Results are identical with and without the macro.

Test Plan:
- DATA_W=64, STEP=1: MULH with data01=0xFFFFFFFFFFFFFFFF (-1), data02=2 -> result_o=0xFFFFFFFFFFFFFFFF; valid_o exactly 66 cycles after accept.
- DIV with 0x8000000000000000 and 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000. REM with the same operands -> 0.
- DIVU with 7 and 0 -> 0xFFFFFFFFFFFFFFFF. REMU with 7 and 0 -> 7. With AS_MULDIV_EARLYOUT_EN, valid_o appears 1 cycle after accept.
- DIVUW with 0x00000000_FFFFFFFE and 2 -> 0x000000007FFFFFFF. REMW with 0x...FFFFFFF9 (-7) and 2 -> 0xFFFFFFFFFFFFFFFF (-1).
- ready_i held low 5 cycles in DONE -> valid_o and result_o stable and ready_o=0 throughout. Then flush_i asserted mid-CALC on a new op -> IDLE next cycle and valid_o never rises.
- Assert rst_i asynchronously mid-CALC, then issue op_i=13 -> all outputs return to reset values immediately after the reset; the op=13 request completes with illegal_o=1 and result_o=0. Repeat a MUL random sweep for STEP=2 and compare against a reference model.
